// File: rtl/register_pkg.sv
// Shared constants for the generic data register.
package register_pkg;

    // Default data width used when the register is instantiated without overrides.
    localparam int DATA_W = 32;

endpackage : register_pkg

// File: rtl/register.sv
// Generic N-bit data register: captures data_i on a rising clock edge when
// enable_i is high, holds otherwise, and clears to RESET_VAL asynchronously
// while resetb_i is high. data_o is driven straight from the storage flops.
module register
    import register_pkg::*;
#(
    parameter int                 nb_bits   = DATA_W,
    parameter logic [nb_bits-1:0] RESET_VAL = '0
) (
    input  logic               clock_i,
    input  logic               resetb_i,
    input  logic [nb_bits-1:0] data_i,
    input  logic               enable_i,
    output logic [nb_bits-1:0] data_o
);

    // A zero-width register has no meaning; stop elaboration outright.
    if (nb_bits < 1) begin : g_width_check
        $fatal(1, "register: nb_bits must be >= 1 (got %0d)", nb_bits);
    end

    logic [nb_bits-1:0] data_d;
    logic [nb_bits-1:0] data_q;

    // Enable mux: take the new input when enabled, otherwise recirculate the stored value.
    always_comb begin
        data_d = enable_i ? data_i : data_q;
    end

    // Storage flops with asynchronous reset to RESET_VAL.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; the reset branch sits in the sensitivity list so the clear
    // takes effect immediately rather than at the next edge.
    always_ff @(posedge clock_i or posedge resetb_i) begin
        if (resetb_i) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

`ifndef SYNTHESIS
    // While reset is held, the output must sit at the reset value.
    a_reset_value : assert property (@(posedge clock_i)
        resetb_i |-> (data_o == RESET_VAL))
        else $error("register: data_o != RESET_VAL while in reset");

    // An edge with enable low (out of reset on both edges) must leave data_o unchanged.
    a_hold : assert property (@(posedge clock_i)
        (!resetb_i && !$past(resetb_i) && !$past(enable_i)) |-> (data_o == $past(data_o)))
        else $error("register: data_o changed with enable_i low");

    // An edge with enable high (out of reset on both edges) must show the sampled input.
    a_capture : assert property (@(posedge clock_i)
        (!resetb_i && !$past(resetb_i) && $past(enable_i)) |-> (data_o == $past(data_i)))
        else $error("register: data_o does not match captured data_i");

    // enable_i must be a known value whenever it can cause a capture.
    a_enable_known : assert property (@(posedge clock_i)
        !resetb_i |-> !$isunknown(enable_i))
        else $error("register: enable_i is X/Z at a clock edge out of reset");
`endif

endmodule : register

// File: tb/tb_register.sv
// Self-checking bench for the generic data register (32 bits, reset value 0).
module tb_register;

    localparam int W = 32;

    logic         clock_i  = 1'b0;
    logic         resetb_i = 1'b1;
    logic [W-1:0] data_i   = 32'hFFFF_FFFF;
    logic         enable_i = 1'b0;
    logic [W-1:0] data_o;

    int checks = 0;
    int errors = 0;

    // Expected outputs, pushed when stimulus is applied, popped after the edge.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model = '0;

    register #(
        .nb_bits  (W),
        .RESET_VAL('0)
    ) dut (
        .clock_i (clock_i),
        .resetb_i(resetb_i),
        .data_i  (data_i),
        .enable_i(enable_i),
        .data_o  (data_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [W-1:0] observed,
                         input logic [W-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Push the expected post-edge value, run one rising edge, then compare 1 ns later.
    task automatic step(input string tag);
        logic [W-1:0] exp_v;
        if (resetb_i)      model = '0;
        else if (enable_i) model = data_i;
        exp_q.push_back(model);
        @(posedge clock_i);
        #1;
        exp_v = exp_q.pop_front();
        check(tag, data_o, exp_v);
    endtask

    initial begin
        // 1. Reset behaviour: output clears with no clock edge, stays cleared.
        #1;
        check("reset_immediate", data_o, 32'h0000_0000);
        step("reset_hold_0");
        enable_i = 1'b1;
        step("reset_hold_en");
        enable_i = 1'b0;
        step("reset_hold_1");

        // 2. Release reset between edges, enable low: nothing captured.
        resetb_i = 1'b0;
        data_i   = 32'h000F_FFFF;
        step("enable_low_0");
        step("enable_low_1");

        // 3. Enabled capture, back-to-back.
        enable_i = 1'b1;
        data_i   = 32'hFFF0_0000;
        step("capture_0");
        data_i   = 32'h1234_5678;
        step("capture_1");

        // 4. Hold with new data on the input, including an enable glitch between edges.
        enable_i = 1'b0;
        data_i   = 32'h8765_4321;
        step("hold_0");
        #2 enable_i = 1'b1;
        #2 enable_i = 1'b0;
        step("hold_glitch");
        step("hold_2");

        // 5. Reset asserted mid-cycle with enable high.
        enable_i = 1'b1;
        data_i   = 32'hAAAA_5555;
        #3 resetb_i = 1'b1;
        #1;
        check("reset_midcycle", data_o, 32'h0000_0000);
        step("reset_override_0");
        step("reset_override_1");

        // 6. Release reset mid-cycle with enable high, then consecutive captures.
        #2;
        resetb_i = 1'b0;
        data_i   = 32'hDEAD_BEEF;
        step("capture_after_reset");
        for (int i = 0; i < 4; i++) begin
            data_i = $urandom();
            step("capture_stream");
        end
        enable_i = 1'b0;
        data_i   = ~data_i;
        step("hold_after_stream");

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Backstop so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish before 100000 ns");
        $fatal(1, "timeout");
    end

endmodule : tb_register
